alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational 32-bit ALU: the same 6-bit opcode set, generalised to WIDTH bits.
- Adds a persistent carry/borrow flag that feeds ADC/SBB, plus registered Z/N flags.
- Adds valid/ready handshakes on input and output, and an iterative multi-cycle shifter.
- Sits between the control unit's issue stage and the register-file write-back.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_shifter.sv | 58 +++++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes,
// FSM states and shifter modes.
package alu_seq_pkg;

  localparam logic [5:0] OP_ADC = 6'b010000;
  localparam logic [5:0] OP_SBB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_LLS = 6'b110000;
  localparam logic [5:0] OP_LRS = 6'b110001;
  localparam logic [5:0] OP_ARS = 6'b110010;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Encoded to match op[1:0] of the shift opcodes
  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_LR = 2'd1,
    SH_AR = 2'd2
  } sh_mode_t;

  function automatic logic is_shift(
    input logic [5:0] op
  );
    return (op == OP_LLS) ||
           (op == OP_LRS) ||
           (op == OP_ARS);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq iterative shifter: one bit per
// cycle, done pulses with the final value.
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  sh_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [SHW-1:0] ONE = SHW'(1);

  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nxt;
  logic [SHW-1:0]   cnt;
  sh_mode_t         mode_q;

  always_comb begin
    nxt = work;
    case (mode_q)
      SH_LL:   nxt = {work[WIDTH-2:0], 1'b0};
      SH_LR:   nxt = {1'b0, work[WIDTH-1:1]};
      default: nxt = {work[WIDTH-1],
                      work[WIDTH-1:1]};
    endcase
  end

  assign done = busy & (cnt == ONE);
  assign res  = nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      cnt    <= '0;
      mode_q <= SH_LL;
      busy   <= 1'b0;
    end else if (start) begin
      work   <= a;
      cnt    <= amt;
      mode_q <= mode;
      busy   <= 1'b1;
    end else if (busy) begin
      work <= nxt;
      cnt  <= cnt - ONE;
      if (cnt == ONE) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent carry,
// valid/ready handshakes and serial shifts.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             op_err,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n
);

  state_t state, state_n;

  logic             acc;
  logic             sh_big;
  logic             sh_zero;
  logic             multi;
  logic             sh_start;
  logic             sh_busy;
  logic             sh_done;
  logic [WIDTH-1:0] sh_res;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             c_upd;
  logic             c_nxt;

  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_err;

  assign in_ready = (state == IDLE) & ~sh_busy
                  & (~out_valid | out_ready);
  assign acc      = in_valid & in_ready;

  assign sh_big   = |b[WIDTH-1:SHW];
  assign sh_zero  = (b == '0);
  assign multi    = is_shift(op) & ~sh_big
                  & ~sh_zero;
  assign sh_start = acc & multi;

  // Carry-in is the flag as of the accept edge
  assign sum = {1'b0, a} + {1'b0, b}
             + {{WIDTH{1'b0}}, flag_c};
  assign dif = {1'b0, a} - {1'b0, b}
             - {{WIDTH{1'b0}}, flag_c};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    c_upd   = 1'b0;
    c_nxt   = flag_c;
    unique case (1'b1)
      (op == OP_ADC): begin
        alu_res = sum[WIDTH-1:0];
        c_upd   = 1'b1;
        c_nxt   = sum[WIDTH];
      end
      (op == OP_SBB): begin
        alu_res = dif[WIDTH-1:0];
        c_upd   = 1'b1;
        c_nxt   = dif[WIDTH];
      end
      (op == OP_EQ): alu_res = WIDTH'(a == b);
      (op == OP_NE): alu_res = WIDTH'(a != b);
      (op == OP_LE): alu_res = WIDTH'(a <= b);
      (op == OP_GT): alu_res = WIDTH'(a > b);
      (op == OP_LLS),
      (op == OP_LRS):
        alu_res = sh_zero ? a : '0;
      (op == OP_ARS):
        alu_res = sh_zero ? a
                : {WIDTH{a[WIDTH-1]}};
      default: alu_err = 1'b1;
    endcase
  end

  assign wr_en  = sh_done | (acc & ~multi);
  assign wr_res = sh_done ? sh_res : alu_res;
  assign wr_err = ~sh_done & alu_err;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (sh_start) state_n = SHIFT;
      SHIFT: if (sh_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  alu_seq_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .start(sh_start),
    .mode (sh_mode_t'(op[1:0])),
    .a    (a),
    .amt  (b[SHW-1:0]),
    .busy (sh_busy),
    .done (sh_done),
    .res  (sh_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      op_err    <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
    end else begin
      state <= state_n;
      if (wr_en) begin
        out_valid <= 1'b1;
        result    <= wr_res;
        op_err    <= wr_err;
        if (!wr_err) begin
          flag_z <= (wr_res == '0);
          flag_n <= wr_res[WIDTH-1];
        end
        if (c_upd & ~sh_done) flag_c <= c_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq
// with hand-computed expected values.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         op_err;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int low;
  int seen;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .op_err   (op_err),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_n   (flag_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic flags(
    input string tag,
    input logic  c,
    input logic  z,
    input logic  n
  );
    chk({tag, "_fl"},
        {29'd0, flag_c, flag_z, flag_n},
        {29'd0, c, z, n});
  endtask

  task automatic issue(
    input logic [5:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int k;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    k  = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("issue_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    op = 6'd0;
    a  = '0;
    b  = '0;
  endtask

  task automatic wait_out();
    cyc = 0;
    low = 0;
    while (!out_valid && cyc < 50) begin
      if (!in_ready) low++;
      step();
      cyc++;
    end
    chk("out_vld", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 6'd0;
    a         = '0;
    b         = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_err", {31'd0, op_err}, 32'd0);
    flags("rst", 1'b0, 1'b0, 1'b0);

    issue(OP_ADC, 32'hFFFF_FFFF, 32'd1);
    wait_out();
    chk("adc1_lat", cyc, 32'd0);
    chk("adc1_res", result, 32'd0);
    chk("adc1_err", {31'd0, op_err}, 32'd0);
    flags("adc1", 1'b1, 1'b1, 1'b0);

    issue(OP_ADC, 32'd0, 32'd0);
    wait_out();
    chk("adc2_res", result, 32'd1);
    flags("adc2", 1'b0, 1'b0, 1'b0);

    issue(OP_SBB, 32'd5, 32'd7);
    wait_out();
    chk("sbb1_res", result, 32'hFFFF_FFFE);
    flags("sbb1", 1'b1, 1'b0, 1'b1);

    issue(OP_SBB, 32'd5, 32'd4);
    wait_out();
    chk("sbb2_res", result, 32'd0);
    flags("sbb2", 1'b0, 1'b1, 1'b0);

    issue(OP_LRS, 32'h8000_0000, 32'd5);
    wait_out();
    chk("lrs_cyc", cyc, 32'd5);
    chk("lrs_low", low, 32'd5);
    chk("lrs_res", result, 32'h0400_0000);
    flags("lrs", 1'b0, 1'b0, 1'b0);

    issue(OP_ARS, 32'h8000_0000, 32'd5);
    wait_out();
    chk("ars_cyc", cyc, 32'd5);
    chk("ars_res", result, 32'hFC00_0000);
    flags("ars", 1'b0, 1'b0, 1'b1);

    issue(OP_LLS, 32'h1234_5678, 32'd40);
    wait_out();
    chk("lls40_lat", cyc, 32'd0);
    chk("lls40_res", result, 32'd0);
    flags("lls40", 1'b0, 1'b1, 1'b0);

    issue(OP_ARS, 32'h8765_4321, 32'd33);
    wait_out();
    chk("ars33_res", result, 32'hFFFF_FFFF);

    issue(OP_LRS, 32'hA5A5_A5A5, 32'd0);
    wait_out();
    chk("lrs0_lat", cyc, 32'd0);
    chk("lrs0_res", result, 32'hA5A5_A5A5);
    flags("lrs0", 1'b0, 1'b0, 1'b1);

    issue(OP_LLS, 32'h0000_0003, 32'd1);
    wait_out();
    chk("lls1_cyc", cyc, 32'd1);
    chk("lls1_res", result, 32'h0000_0006);

    issue(OP_LE, 32'd9, 32'd9);
    wait_out();
    chk("le_res", result, 32'd1);

    out_ready = 1'b0;
    issue(OP_GT, 32'd3, 32'd2);
    wait_out();
    chk("gt_res", result, 32'd1);
    in_valid = 1'b1;
    op = OP_NE;
    a  = 32'd7;
    b  = 32'd7;
    chk("hold_rdy0", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("hold_vld", {31'd0, out_valid}, 32'd1);
    chk("hold_res", result, 32'd1);
    chk("hold_rdy1", {31'd0, in_ready}, 32'd0);
    flags("hold", 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("dlv_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("dlv_vld", {31'd0, out_valid}, 32'd1);
    chk("ne_res", result, 32'd0);
    flags("ne", 1'b0, 1'b1, 1'b0);

    issue(OP_SBB, 32'd5, 32'd7);
    wait_out();
    flags("sbb3", 1'b1, 1'b0, 1'b1);
    issue(6'b111111, 32'd1, 32'd2);
    wait_out();
    chk("ill_lat", cyc, 32'd0);
    chk("ill_err", {31'd0, op_err}, 32'd1);
    chk("ill_res", result, 32'd0);
    flags("ill", 1'b1, 1'b0, 1'b1);
    issue(OP_EQ, 32'd7, 32'd7);
    wait_out();
    chk("eq_err", {31'd0, op_err}, 32'd0);
    chk("eq_res", result, 32'd1);
    flags("eq", 1'b1, 1'b0, 1'b0);

    issue(OP_LLS, 32'd1, 32'd10);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_res", result, 32'd0);
    flags("mrst", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mrst_stale", seen, 32'd0);

    issue(OP_ADC, 32'd1, 32'd2);
    wait_out();
    chk("post_res", result, 32'd3);
    flags("post", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
